// File: rtl/wb_arbiter.sv
// Write-back arbiter: MEM results take the register write port first, buffered divider results fill idle slots.
// Writes are registered (1 cycle); divider results are back-pressured with div_ready_o when the buffer is full.
module wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DIV_FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]    mem_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        mem_wr_data_i,
    input  logic                         div_issue_i,
    input  logic [REG_ADDR_WIDTH-1:0]    div_issue_addr_i,
    input  logic                         div_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]    div_addr_i,
    input  logic [DATA_WIDTH-1:0]        div_data_i,
    output logic                         div_ready_o,
    output logic                         reg_wr_en_o,
    output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_o,
    output logic [DATA_WIDTH-1:0]        reg_wr_data_o,
    output logic [2**REG_ADDR_WIDTH-1:0] busy_o
);

    localparam int NREG = 2**REG_ADDR_WIDTH;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
    } div_entry_t;

    div_entry_t          push_dat;
    div_entry_t          head_dat;
    logic                fifo_empty;
    logic                fifo_full;
    logic                mem_sel;
    logic                div_push;
    logic                div_pop;
    logic                head_wr;
    logic [NREG-1:0]     busy_nxt;

    // An x0 destination from MEM is a bubble, so the slot goes to the buffer.
    assign mem_sel     = mem_wr_en_i && (mem_wr_addr_i != '0);
    assign div_ready_o = !fifo_full;
    assign div_push    = div_valid_i && div_ready_o;
    assign div_pop     = !mem_sel && !fifo_empty;
    assign head_wr     = div_pop && (head_dat.addr != '0);

    assign push_dat.addr = div_addr_i;
    assign push_dat.data = div_data_i;

    wb_arbiter_fifo #(
        .WIDTH ($bits(div_entry_t)),
        .DEPTH (DIV_FIFO_DEPTH)
    ) u_div_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (div_push),
        .push_dat (push_dat),
        .pop      (div_pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr_en_o   <= 1'b0;
            reg_wr_addr_o <= '0;
            reg_wr_data_o <= '0;
        end else if (mem_sel) begin
            reg_wr_en_o   <= 1'b1;
            reg_wr_addr_o <= mem_wr_addr_i;
            reg_wr_data_o <= mem_wr_data_i;
        end else if (head_wr) begin
            reg_wr_en_o   <= 1'b1;
            reg_wr_addr_o <= head_dat.addr;
            reg_wr_data_o <= head_dat.data;
        end else begin
            reg_wr_en_o   <= 1'b0;
        end
    end

    // Clear first, then set, so a re-issue to the register being retired keeps it busy.
    always_comb begin
        busy_nxt = busy_o;
        if (head_wr) begin
            busy_nxt[head_dat.addr] = 1'b0;
        end
        if (div_issue_i && (div_issue_addr_i != '0)) begin
            busy_nxt[div_issue_addr_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o <= '0;
        end else begin
            busy_o <= busy_nxt;
        end
    end

endmodule

// Small synchronous FIFO holding buffered divider results in arrival order.
// Head is visible combinationally; full refuses push regardless of a same-cycle pop.
module wb_arbiter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes queued with their cycle, a negedge monitor pops and compares.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem_wr_en_i;
    logic [4:0]  mem_wr_addr_i;
    logic [31:0] mem_wr_data_i;
    logic        div_issue_i;
    logic [4:0]  div_issue_addr_i;
    logic        div_valid_i;
    logic [4:0]  div_addr_i;
    logic [31:0] div_data_i;
    logic        div_ready_o;
    logic        reg_wr_en_o;
    logic [4:0]  reg_wr_addr_o;
    logic [31:0] reg_wr_data_o;
    logic [31:0] busy_o;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   passes;

    wb_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_wr_en_i      (mem_wr_en_i),
        .mem_wr_addr_i    (mem_wr_addr_i),
        .mem_wr_data_i    (mem_wr_data_i),
        .div_issue_i      (div_issue_i),
        .div_issue_addr_i (div_issue_addr_i),
        .div_valid_i      (div_valid_i),
        .div_addr_i       (div_addr_i),
        .div_data_i       (div_data_i),
        .div_ready_o      (div_ready_o),
        .reg_wr_en_o      (reg_wr_en_o),
        .reg_wr_addr_o    (reg_wr_addr_o),
        .reg_wr_data_o    (reg_wr_data_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int c, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic mem(input logic en, input logic [4:0] a, input logic [31:0] d);
        mem_wr_en_i   = en;
        mem_wr_addr_i = a;
        mem_wr_data_i = d;
    endtask

    task automatic div(input logic v, input logic [4:0] a, input logic [31:0] d);
        div_valid_i = v;
        div_addr_i  = a;
        div_data_i  = d;
    endtask

    task automatic issue(input logic v, input logic [4:0] a);
        div_issue_i      = v;
        div_issue_addr_i = a;
    endtask

    task automatic idle();
        mem(1'b0, 5'd0, 32'd0);
        div(1'b0, 5'd0, 32'd0);
        issue(1'b0, 5'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_en_o) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_write: got x%0d=%0h at cycle %0d, expected none",
                             reg_wr_addr_o, reg_wr_data_o, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.cyc == cyc && e.addr == reg_wr_addr_o && e.data == reg_wr_data_o) passes++;
                    else $display("FAIL write: got x%0d=%0h at cycle %0d, expected x%0d=%0h at cycle %0d",
                                  reg_wr_addr_o, reg_wr_data_o, cyc, e.addr, e.data, e.cyc);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                checks++;
                $display("FAIL missed_write: got no write at cycle %0d, expected x%0d=%0h",
                         cyc, q[0].addr, q[0].data);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int c;
        checks = 0;
        passes = 0;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_en", reg_wr_en_o, 0);
        chk("rst_wr_addr", reg_wr_addr_o, 0);
        chk("rst_wr_data", reg_wr_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_div_ready", div_ready_o, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // MEM write x5 appears exactly one cycle later
        tick(); c = cyc;
        expect_wr(c + 1, 5'd5, 32'h1234);
        mem(1'b1, 5'd5, 32'h1234);
        tick(); idle();
        tick(); tick();

        // Divide to x7: busy until popped, write two cycles after handshake
        tick(); c = cyc;
        expect_wr(c + 3, 5'd7, 32'hDEAD);
        issue(1'b1, 5'd7);
        tick(); issue(1'b0, 5'd0);
        div(1'b1, 5'd7, 32'hDEAD);
        @(negedge clk);
        chk("busy7_set", busy_o[7], 1);
        chk("ready_x7", div_ready_o, 1);
        tick(); idle();
        @(negedge clk);
        chk("busy7_pop_cycle", busy_o[7], 1);
        tick();
        @(negedge clk);
        chk("busy7_cleared", busy_o[7], 0);
        tick(); tick();

        // MEM stream blocks the buffer; third result refused while full
        tick(); c = cyc;
        expect_wr(c + 1, 5'd1, 32'h101);
        expect_wr(c + 2, 5'd2, 32'h102);
        expect_wr(c + 3, 5'd3, 32'h103);
        expect_wr(c + 4, 5'd4, 32'h104);
        expect_wr(c + 5, 5'd10, 32'hA0);
        expect_wr(c + 6, 5'd11, 32'hA1);
        mem(1'b1, 5'd1, 32'h101); div(1'b1, 5'd10, 32'hA0);
        tick(); mem(1'b1, 5'd2, 32'h102); div(1'b1, 5'd11, 32'hA1);
        @(negedge clk); chk("stream_ready_c1", div_ready_o, 1);
        tick(); mem(1'b1, 5'd3, 32'h103); div(1'b1, 5'd12, 32'hA2);
        @(negedge clk); chk("stream_ready_full", div_ready_o, 0);
        tick(); mem(1'b1, 5'd4, 32'h104);
        @(negedge clk); chk("stream_ready_c3", div_ready_o, 0);
        tick(); mem(1'b0, 5'd0, 32'd0); div(1'b1, 5'd13, 32'hA3);
        @(negedge clk); chk("full_pop_no_push", div_ready_o, 0);
        tick(); idle();
        @(negedge clk); chk("stream_ready_drain", div_ready_o, 1);
        tick(); tick(); tick();

        // x0 from MEM and divider: no writes, FIFO returns to empty
        tick(); c = cyc;
        expect_wr(c + 3, 5'd3, 32'h303);
        expect_wr(c + 4, 5'd4, 32'h404);
        expect_wr(c + 5, 5'd5, 32'h505);
        expect_wr(c + 6, 5'd20, 32'h2020);
        expect_wr(c + 7, 5'd21, 32'h2121);
        mem(1'b1, 5'd0, 32'hBAD); div(1'b1, 5'd0, 32'hBEEF);
        tick(); mem(1'b1, 5'd0, 32'hBAD2); div(1'b0, 5'd0, 32'd0);
        tick(); mem(1'b1, 5'd3, 32'h303); div(1'b1, 5'd20, 32'h2020);
        tick(); mem(1'b1, 5'd4, 32'h404); div(1'b1, 5'd21, 32'h2121);
        @(negedge clk); chk("x0_drained_ready", div_ready_o, 1);
        tick(); mem(1'b1, 5'd5, 32'h505); div(1'b0, 5'd0, 32'd0);
        @(negedge clk); chk("x0_refill_full", div_ready_o, 0);
        tick(); idle();
        tick(); tick(); tick(); tick();

        // Pop of x9 coincident with re-issue to x9
        tick(); c = cyc;
        expect_wr(c + 3, 5'd9, 32'h99);
        issue(1'b1, 5'd9);
        tick(); issue(1'b0, 5'd0); div(1'b1, 5'd9, 32'h99);
        @(negedge clk); chk("busy9_issue", busy_o[9], 1);
        tick(); div(1'b0, 5'd0, 32'd0); issue(1'b1, 5'd9);
        @(negedge clk); chk("busy9_pop_cycle", busy_o[9], 1);
        tick(); idle();
        @(negedge clk); chk("busy9_set_wins", busy_o[9], 1);
        tick();
        @(negedge clk); chk("busy9_hold", busy_o[9], 1);

        // Reset with FIFO full and busy bits set
        tick(); c = cyc;
        expect_wr(c + 1, 5'd1, 32'h111);
        issue(1'b1, 5'd3); mem(1'b1, 5'd1, 32'h111); div(1'b1, 5'd14, 32'hE);
        tick(); issue(1'b0, 5'd0); mem(1'b1, 5'd2, 32'h222); div(1'b1, 5'd15, 32'hF);
        tick(); mem(1'b1, 5'd6, 32'h666); div(1'b0, 5'd0, 32'd0);
        #1;
        chk("pre_rst_full", div_ready_o, 0);
        chk("pre_rst_busy", busy_o, 32'h0000_0208);
        chk("pre_rst_wr_en", reg_wr_en_o, 1);
        #1 rst_n = 1'b0;
        idle();
        #1;
        chk("arst_wr_en", reg_wr_en_o, 0);
        chk("arst_wr_addr", reg_wr_addr_o, 0);
        chk("arst_wr_data", reg_wr_data_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_ready", div_ready_o, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_ready", div_ready_o, 1);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        @(negedge clk);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_ready", div_ready_o, 1);
        tick(); c = cyc;
        expect_wr(c + 1, 5'd8, 32'h888);
        mem(1'b1, 5'd8, 32'h888);
        tick(); idle();
        tick(); tick(); tick();

        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
